// File: rtl/lower_layer_run_collector.sv
// Run collector: buffers one sorted run from the merge stage, checks its order,
// then replays it downstream with a valid/ready handshake and an end-of-run flag.
module lower_layer_run_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      run_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  order_err,
  output logic                  run_done
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      len_reg;
  logic [CNT_W-1:0]      wr_ptr_reg;
  logic [CNT_W-1:0]      rd_ptr_reg;
  logic [DATA_WIDTH-1:0] prev_reg;
  logic                  order_err_reg;
  logic                  run_done_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic start_ok;
  logic accept;
  logic last_accept;
  logic xfer;
  logic last_xfer;

  assign start_ok    = (state_reg == IDLE) && start && (run_len != '0) &&
                       (run_len <= CNT_W'(DEPTH));
  assign accept      = (state_reg == FILL) && in_valid;
  assign last_accept = accept && ((wr_ptr_reg + CNT_W'(1)) == len_reg);
  assign xfer        = (state_reg == DRAIN) && out_ready;
  assign last_xfer   = xfer && out_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok)    state_next = FILL;
      FILL:    if (last_accept) state_next = DRAIN;
      DRAIN:   if (last_xfer)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Outputs; out_data is forced to zero outside DRAIN so idle outputs read 0
  always_comb begin
    in_ready  = (state_reg == FILL);
    out_valid = (state_reg == DRAIN);
    out_last  = (state_reg == DRAIN) && (rd_ptr_reg == (len_reg - CNT_W'(1)));
    out_data  = (state_reg == DRAIN) ? mem[rd_ptr_reg[ADDR_W-1:0]] : '0;
    busy      = (state_reg != IDLE);
    order_err = order_err_reg;
    run_done  = run_done_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg       <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      prev_reg      <= '0;
      order_err_reg <= 1'b0;
      run_done_reg  <= 1'b0;
    end else begin
      run_done_reg <= last_xfer;
      if (start_ok) begin
        len_reg       <= run_len;
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        order_err_reg <= 1'b0;
      end
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + CNT_W'(1);
        prev_reg   <= in_data;
        // The first element of a run has no predecessor to compare against
        if ((wr_ptr_reg != '0) && (in_data < prev_reg)) order_err_reg <= 1'b1;
      end
      if (xfer) rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
    end
  end

  // Buffer storage carries no reset; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_reg[ADDR_W-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_lower_layer_run_collector.sv
// Randomized self-checking bench for lower_layer_run_collector; expectations come
// from the run contents held in the bench (replay order, last flag, order check).
module tb_lower_layer_run_collector;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] run_len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          order_err;
  logic          run_done;

  int checks   = 0;
  int failures = 0;

  int run_data[$];

  lower_layer_run_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .run_len(run_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .order_err(order_err), .run_done(run_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // True if any of the first n elements of the run is below its predecessor
  function automatic bit prefix_err(input int n);
    for (int i = 1; i < n; i++)
      if (run_data[i] < run_data[i-1]) return 1'b1;
    return 1'b0;
  endfunction

  // Runs run_data through the DUT starting at the current falling edge.
  // Returns at the falling edge in which run_done should be high.
  task automatic run_one(input int gap_pct, input int stall_pct);
    int n = run_data.size();
    int idx = 0;
    int rd = 0;
    int budget;
    chk("idle_before_start", busy, 0);
    start = 1'b1;
    run_len = CW'(n);
    @(negedge clk);
    start = 1'b0;
    budget = 500;
    while (idx < n && budget > 0) begin
      chk("fill_in_ready", in_ready, 1);
      chk("fill_out_valid", out_valid, 0);
      chk("fill_order_err", order_err, prefix_err(idx));
      if ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = DW'(run_data[idx]);
        idx++;
      end
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("fill_timeout", 0, 1);
    in_valid = 1'b0;
    budget = 500;
    while (budget > 0) begin
      chk("drain_in_ready", in_ready, 0);
      chk("drain_out_valid", out_valid, 1);
      chk("drain_out_data", out_data, run_data[rd]);
      chk("drain_out_last", out_last, (rd == n - 1));
      chk("drain_run_done", run_done, 0);
      chk("drain_order_err", order_err, prefix_err(n));
      if ($urandom_range(0, 99) < stall_pct) begin
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
        rd++;
      end
      @(negedge clk);
      budget--;
      if (rd == n) break;
    end
    if (budget == 0) chk("drain_timeout", 0, 1);
    out_ready = 1'b0;
    chk("run_done_pulse", run_done, 1);
    chk("done_busy", busy, 0);
    chk("done_out_valid", out_valid, 0);
    chk("done_order_err", order_err, prefix_err(n));
    $display("run len=%0d err=%0d done at %0t", n, prefix_err(n), $time);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_run_done_low", run_done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int v;
    rst = 1'b1; start = 1'b0; run_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_order_err", order_err, 0);
    chk("rst_run_done", run_done, 0);

    // Basic back-to-back run
    run_data = '{3, 5, 5, 9};
    run_one(0, 0);
    idle_cycle();

    // Backpressure
    run_data = '{1, 2, 7};
    run_one(0, 50);
    idle_cycle();

    // Order error; stays sticky through idle and ignored starts
    run_data = '{10, 4, 12, 12};
    run_one(0, 0);
    idle_cycle();
    start = 1'b1; run_len = '0;
    @(negedge clk);
    chk("len0_ignored", busy, 0);
    run_len = CW'(DEPTH + 1);
    @(negedge clk);
    chk("len9_ignored", busy, 0);
    chk("ignored_keeps_err", order_err, 1);
    start = 1'b0;
    @(negedge clk);
    chk("len9_still_idle", busy, 0);

    // Full-depth run with input gaps
    run_data = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_one(40, 20);
    idle_cycle();

    // Reset in the middle of a fill (with an order error already latched)
    start = 1'b1; run_len = CW'(4);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'd5;
    @(negedge clk);
    in_data = 8'd2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_order_err", order_err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_order_err", order_err, 0);
    run_data = '{6, 8};
    run_one(0, 0);

    // Start in the run_done cycle
    run_data = '{20, 21};
    run_one(0, 0);
    run_data = '{4, 4, 1};
    run_one(20, 20);
    idle_cycle();

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(1, DEPTH);
      bit sorted = $urandom_range(0, 1);
      run_data = {};
      v = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) begin
        if (sorted) v = v + $urandom_range(0, 30);
        else v = $urandom_range(0, 255);
        if (v > 255) v = 255;
        run_data.push_back(v);
      end
      run_one($urandom_range(0, 60), $urandom_range(0, 60));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
